// File: rtl/slot_counter.sv
// Slot cycle counter: counts 0..TICK_DIV-1 and wraps, with clear and hold.
// Latency: the registered count updates on every rising edge; tc_o and cnt_nxt_o are combinational.
// Backpressure: holding inc_i low freezes the count; clr_i has priority over inc_i.
module slot_counter #(
  parameter int TICK_DIV = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_nxt_o,
  output logic             tc_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc_o      = (cnt_q == LAST);
  assign cnt_nxt_o = cnt_d;

  // Next count: clear wins, otherwise advance and wrap at the terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scan driver for a 2-to-4 decoder: rotates sel 0..3 with a blanked start in each slot.
// Latency: outputs update one edge after start; slot_tick is combinational in the last slot cycle.
// Backpressure: hold freezes counter, sel and en; stop aborts at the next edge and overrides hold.
module decoder_scan_ctrl #(
  parameter int TICK_DIV = 4,
  parameter int BLANK    = 1,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       mode,
  input  logic       hold,
  output logic [1:0] sel,
  output logic       en,
  output logic       busy,
  output logic       done,
  output logic       slot_tick
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] BLANK_C = CNT_W'(BLANK);

  state_e           state_q;
  logic [1:0]       sel_q;
  logic             en_q;
  logic             busy_q;
  logic             done_q;
  logic             mode_q;

  logic [CNT_W-1:0] cnt_nxt;
  logic             tc;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             sweep_end;

  // A single sweep finishes on the edge that closes slot 3, unless stop pre-empts it.
  assign sweep_end = (state_q == SCAN) && !stop && !hold && tc && mode_q && (sel_q == 2'd3);
  assign cnt_clr   = (state_q == IDLE) || stop || sweep_end;
  assign cnt_inc   = (state_q == SCAN) && !hold;
  assign slot_tick = (state_q == SCAN) && tc && !hold;

  slot_counter #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_slot_counter (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (cnt_clr),
    .inc_i     (cnt_inc),
    .cnt_nxt_o (cnt_nxt),
    .tc_o      (tc)
  );

  // Scan FSM with registered sel/en/busy/done; en tracks the counter's next value so both move together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            state_q <= SCAN;
            sel_q   <= 2'd0;
            busy_q  <= 1'b1;
            mode_q  <= mode;
            en_q    <= (BLANK_C == '0);
          end
        end
        SCAN: begin
          if (stop || sweep_end) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= sweep_end;
          end else if (!hold) begin
            en_q <= (cnt_nxt >= BLANK_C);
            if (tc) begin
              sel_q <= sel_q + 2'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sel  = sel_q;
  assign en   = en_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Bench for decoder_scan_ctrl: reference model + scoreboard queue, a sweep vector table,
// and directed sequences for hold, stop, start/stop collisions, done/start overlap, reset and BLANK = 0.
// A stand-in 2-to-4 decoder derived from sel/en is checked against the expected one-hot value.
module tb_decoder_scan_ctrl;

  localparam int TD = 4;
  localparam int BL = 1;

  logic       clk = 1'b0;
  logic       reset, start, stop, mode, hold;
  logic [1:0] sel, sel_b;
  logic       en, busy, done, tick;
  logic       en_b, busy_b, done_b, tick_b;
  logic [3:0] dec;

  always #5 clk = ~clk;

  decoder_scan_ctrl #(.TICK_DIV(TD), .BLANK(BL), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode), .hold(hold),
    .sel(sel), .en(en), .busy(busy), .done(done), .slot_tick(tick)
  );

  decoder_scan_ctrl #(.TICK_DIV(TD), .BLANK(0), .CNT_W(8)) dut_b0 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode), .hold(hold),
    .sel(sel_b), .en(en_b), .busy(busy_b), .done(done_b), .slot_tick(tick_b)
  );

  // 2-to-4 decoder driven by the scan controller.
  assign dec = en ? (4'b0001 << sel) : 4'b0000;

  typedef struct packed {
    logic [1:0] sel;
    logic       en;
    logic       busy;
    logic       done;
  } obs_t;

  obs_t q[$];
  obs_t vec[18];
  int   tests = 0;
  int   fails = 0;
  int   tick_cnt = 0;
  int   done_cnt = 0;
  int   enb_cnt = 0;

  // Reference model state.
  int   m_state = 0;
  int   m_sel = 0;
  int   m_cnt = 0;
  int   m_mode = 0;
  bit   m_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.sel  = 2'(m_sel);
    o.en   = (m_state == 1) && (m_cnt >= BL);
    o.busy = (m_state == 1);
    o.done = m_done;
    return o;
  endfunction

  task automatic model_step(input logic r, input logic s, input logic p, input logic md, input logic h);
    m_done = 0;
    if (r) begin
      m_state = 0; m_sel = 0; m_cnt = 0; m_mode = 0;
    end else if (m_state == 0) begin
      if (s && !p) begin
        m_state = 1; m_sel = 0; m_cnt = 0; m_mode = md;
      end
    end else if (p) begin
      m_state = 0; m_sel = 0; m_cnt = 0;
    end else if (!h) begin
      if (m_cnt == TD - 1) begin
        m_cnt = 0;
        if (m_mode == 1 && m_sel == 3) begin
          m_state = 0; m_sel = 0; m_done = 1;
        end else begin
          m_sel = (m_sel + 1) % 4;
        end
      end else begin
        m_cnt++;
      end
    end
  endtask

  // One clock: drive at negedge, check slot_tick, push expected post-edge outputs, pop after the edge.
  task automatic cyc(input logic r, input logic s, input logic p, input logic md, input logic h);
    obs_t e;
    @(negedge clk);
    reset = r; start = s; stop = p; mode = md; hold = h;
    #1;
    check("slot_tick", 32'(tick), 32'((m_state == 1) && (m_cnt == TD - 1) && !h));
    if (tick === 1'b1) tick_cnt++;
    model_step(r, s, p, md, h);
    q.push_back(model_obs());
    @(posedge clk);
    #1;
    e = q.pop_front();
    check("outputs", 32'({sel, en, busy, done}), 32'(e));
    check("decoder", 32'(dec), 32'(e.en ? (4'b0001 << e.sel) : 4'b0000));
    if (done === 1'b1) done_cnt++;
    if (en_b === 1'b1) enb_cnt++;
  endtask

  initial begin
    logic sv_en;

    // Expected outputs after each edge of a single sweep started with a one-cycle start.
    for (int i = 0; i < 16; i++) begin
      vec[i].sel  = 2'(i / 4);
      vec[i].en   = (i % 4) != 0;
      vec[i].busy = 1'b1;
      vec[i].done = 1'b0;
    end
    vec[16] = '{sel: 2'd0, en: 1'b0, busy: 1'b0, done: 1'b1};
    vec[17] = '{sel: 2'd0, en: 1'b0, busy: 1'b0, done: 1'b0};

    reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; hold = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state
    cyc(1, 0, 0, 0, 0);
    check("reset_state", 32'({sel, en, busy, done, tick}), 32'd0);

    // Test 1: single sweep against the vector table
    done_cnt = 0;
    for (int i = 0; i < 18; i++) begin
      cyc(0, (i == 0), 0, 1, 0);
      check("sweep_vec", 32'({sel, en, busy, done}), 32'(vec[i]));
    end
    check("sweep_done_count", 32'(done_cnt), 32'd1);

    // Test 2: continuous scan for 40 cycles
    tick_cnt = 0; done_cnt = 0;
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 40; i++) cyc(0, 0, 0, 0, 0);
    check("cont_tick_count", 32'(tick_cnt), 32'd10);
    check("cont_done_count", 32'(done_cnt), 32'd0);
    check("cont_busy", 32'(busy), 32'd1);
    cyc(0, 0, 1, 0, 0);
    check("cont_stop", 32'({sel, en, busy, done}), 32'd0);

    // Test 3: hold at sel = 1, cnt = 2 for 5 cycles
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0);
    check("hold_pre_sel", 32'(sel), 32'd1);
    sv_en = en;
    tick_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 1);
      check("hold_frozen", 32'({sel, en}), 32'({2'd1, sv_en}));
    end
    check("hold_no_tick", 32'(tick_cnt), 32'd0);
    cyc(0, 0, 0, 0, 0);
    check("hold_resume1", 32'(sel), 32'd1);
    cyc(0, 0, 0, 0, 0);
    check("hold_resume2", 32'({sel, en}), 32'({2'd2, 1'b0}));
    check("hold_resume_tick", 32'(tick_cnt), 32'd1);
    cyc(0, 0, 1, 0, 0);

    // Test 4: start and stop together in IDLE
    cyc(0, 1, 1, 0, 0);
    check("start_stop_idle", 32'({busy, en}), 32'd0);
    cyc(0, 0, 0, 0, 0);
    check("start_stop_idle2", 32'(busy), 32'd0);

    // Test 5a: stop in the final cycle of a sweep beats done
    done_cnt = 0;
    cyc(0, 1, 0, 1, 0);
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 1, 0);
    check("pre_stop_sel", 32'(sel), 32'd3);
    cyc(0, 0, 1, 1, 0);
    check("final_stop", 32'({busy, done}), 32'd0);
    cyc(0, 0, 0, 1, 0);
    check("final_stop_nodone", 32'(done_cnt), 32'd0);

    // Test 5b: start during the done cycle starts a new sweep
    cyc(0, 1, 0, 1, 0);
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    check("done_pulse", 32'({done, busy}), 32'({1'b1, 1'b0}));
    cyc(0, 1, 0, 1, 0);
    check("restart_on_done", 32'({busy, sel, done}), 32'({1'b1, 2'd0, 1'b0}));
    cyc(0, 0, 1, 0, 0);

    // Test 6: reset mid-scan at sel = 2 with en high
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 0);
    check("pre_reset", 32'({sel, en}), 32'({2'd2, 1'b1}));
    cyc(1, 0, 0, 0, 0);
    check("mid_reset", 32'({sel, en, busy, done}), 32'd0);
    cyc(0, 0, 0, 0, 0);
    check("post_reset_idle", 32'({busy, tick}), 32'd0);

    // BLANK = 0: en stays high for all 16 cycles of a sweep
    enb_cnt = 0;
    cyc(0, 1, 0, 1, 0);
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    check("blank0_en_cycles", 32'(enb_cnt), 32'd16);
    check("blank0_done", 32'({done_b, en_b, busy_b}), 32'({1'b1, 1'b0, 1'b0}));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decoder_scan_ctrl.md
Name: decoder_scan_ctrl

Overview:
- Sequential driver placed directly upstream of the 2-to-4 decoder.
- Produces the decoder's 2-bit select and enable so that decoder outputs 0..3 are activated one at a time in rotation, for digit or row multiplexing.
- Each select slot has a programmable length, with a blanking interval at the start of the slot to suppress ghosting.
- Two modes: continuous scanning, or a single sweep that ends with a done pulse.

Parameters:
- TICK_DIV, 4: clock cycles per select slot; legal range 2..255.
- BLANK, 1: cycles at the start of each slot during which en is held low; legal range 0..TICK_DIV-1.
- CNT_W, 8: width of the slot cycle counter; must satisfy 2^CNT_W >= TICK_DIV.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin scanning; sampled only in IDLE.
- stop  input  1  abort scanning; wins over start in the same cycle.
- mode  input  1  0 = continuous, 1 = single sweep (slots 0..3, then stop); sampled with start.
- hold  input  1  freeze the slot counter and select; en is held at its current value.
- sel  output  2  decoder select; sel[1] drives the MSB decoder input, sel[0] the LSB.
- en  output  1  decoder enable.
- busy  output  1  high while in SCAN.
- done  output  1  one-cycle pulse at the end of a single sweep.
- slot_tick  output  1  one-cycle pulse in the last cycle of every slot.

Behaviour:
- Reset: one clock, synchronous, active-high. Reset in any state forces state = IDLE, sel = 0, en = 0, busy = 0, done = 0, slot_tick = 0, cnt = 0, mode_q = 0. Reset mid-scan aborts immediately; no done pulse.
- State machine, IDLE:
  - start = 1 and stop = 0 at edge N: after edge N, state = SCAN, sel = 0, cnt = 0, busy = 1, mode_q = mode.
  - start while in SCAN is ignored.
- State machine, SCAN:
  - cnt increments every cycle while hold = 0.
  - While cnt = TICK_DIV-1: slot_tick = 1 (combinational from cnt and state, gated by hold = 0).
  - At that edge cnt returns to 0 and sel advances, wrapping 3 -> 0.
- Enable rule: en = 1 iff state = SCAN and cnt >= BLANK. en is registered so it changes in the same edge as cnt. With BLANK = 0, en stays high for the whole scan.
- Single sweep (mode_q = 1): at the edge ending slot 3 (sel = 3, cnt = TICK_DIV-1, hold = 0):
  - state goes to IDLE; sel, en and busy go to 0; cnt = 0.
  - done = 1 for exactly one cycle.
  - Total busy time is 4*TICK_DIV cycles.
- Continuous (mode_q = 0): sel wraps to 0 and scanning continues until stop; done is never asserted.
- stop in SCAN: at the next edge, state = IDLE; sel, en, busy and cnt go to 0; no done pulse. stop in IDLE has no effect.
- hold: cnt, sel and en freeze and slot_tick is suppressed. stop still overrides hold.
- Simultaneous events:
  - stop during the final cycle of a single sweep wins; no done pulse.
  - start in the same cycle as the done pulse is accepted, because state is already IDLE in that cycle.
- Width rule: cnt is CNT_W bits unsigned and never exceeds TICK_DIV-1.
- sel changes only at slot boundaries, always while en = 0 when BLANK >= 1 (break-before-make).

Decomposition:
- No shared package needed. State encoding (IDLE = 1'b0, SCAN = 1'b1) is a localparam inside the module.
- One natural sub-module, slot_counter: CNT_W-bit counter with clear, hold and terminal-count output (cnt == TICK_DIV-1). The FSM, sel register and en logic stay in decoder_scan_ctrl.
- Integration testbench instantiates decoder_scan_ctrl feeding decoderTwotoFour and checks one-hot outputs.

Test Plan:
1. Reset, then mode = 1, TICK_DIV = 4, BLANK = 1, one-cycle start -> sel sequence 0,0,0,0,1,1,1,1,2,...,3. en pattern per slot is 0,1,1,1. busy high for 16 cycles, then done = 1 for one cycle. Decoder output is one-hot, and all zero during blank cycles.
2. mode = 0, start, run 40 cycles -> sel wraps 3 -> 0 at cycle 16 and 32. slot_tick pulses every 4 cycles. done stays 0.
3. Continuous scan, assert hold for 5 cycles at cnt = 2, sel = 1 -> sel, cnt and en unchanged for 5 cycles; no slot_tick. Slot 1 resumes and completes 2 cycles after hold drops.
4. start and stop in the same cycle in IDLE -> stays IDLE; busy = 0, en = 0.
5. Single sweep; assert stop while sel = 3, cnt = 3 -> next cycle IDLE, done = 0. Separately, start during the done cycle -> new sweep begins with sel = 0.
6. reset mid-scan (sel = 2, en = 1) -> next cycle all outputs 0, state IDLE. BLANK = 0 case: en high for all 16 cycles of a sweep.
